// File: rtl/rpn_stack_engine_if.sv
// Operand/command bus between the number builder and the RPN stack engine,
// plus the status bus going to the display logic.
interface rpn_stack_engine_if #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
);
  logic [DW-1:0]            number;
  logic                     push;
  logic                     op_strobe;
  logic [2:0]               op_code;
  logic [DW-1:0]            top;
  logic [$clog2(DEPTH):0]   depth;
  logic                     busy;
  logic                     done;
  logic                     err_overflow;
  logic                     err_underflow;
  logic                     err_illegal;

  modport master (
    output number, push, op_strobe, op_code,
    input  top, depth, busy, done, err_overflow, err_underflow, err_illegal
  );

  modport slave (
    input  number, push, op_strobe, op_code,
    output top, depth, busy, done, err_overflow, err_underflow, err_illegal
  );
endinterface

// File: rtl/rpn_stack_engine.sv
// Reverse-Polish evaluator: LIFO register stack with single-cycle push/DROP/DUP
// and a three-state FSM for the binary operators and SWAP.
module rpn_stack_engine #(
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic               clk,
  input  logic               clear,
  rpn_stack_engine_if.slave  bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WRITE} state_e;
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_SWAP = 3'b011,
    OP_DROP = 3'b100,
    OP_DUP  = 3'b101
  } opcode_e;

  state_e          state_q, state_d;
  logic [SPW-1:0]  sp_q, sp_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [DW-1:0]   r_q, r_d;
  opcode_e         opc_q, opc_d;
  logic            done_q, done_d;
  logic            errOvf_q, errUnd_q, errIll_q;
  logic [DW-1:0]   stack_q [DEPTH];

  logic            commit, ovfSet, undSet, illSet;
  logic            wr0En, wr1En;
  logic [AW-1:0]   wr0Addr, wr1Addr;
  logic [DW-1:0]   wr0Data, wr1Data;
  logic [AW-1:0]   freeIdx, tosIdx, nosIdx;
  logic            isEmpty, isFull;

  // Index arithmetic wraps in AW bits, so sp==DEPTH still maps TOS to DEPTH-1.
  assign freeIdx = sp_q[AW-1:0];
  assign tosIdx  = sp_q[AW-1:0] - AW'(1);
  assign nosIdx  = sp_q[AW-1:0] - AW'(2);
  assign isEmpty = (sp_q == '0);
  assign isFull  = (sp_q == SPW'(DEPTH));

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    opc_d   = opc_q;
    commit  = 1'b0;
    ovfSet  = 1'b0;
    undSet  = 1'b0;
    illSet  = 1'b0;
    wr0En   = 1'b0;
    wr0Addr = freeIdx;
    wr0Data = bus.number;
    wr1En   = 1'b0;
    wr1Addr = tosIdx;
    wr1Data = b_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.push) begin
          // A push always wins over a simultaneous op; the op is flagged and dropped.
          illSet = bus.op_strobe;
          if (isFull) begin
            ovfSet = 1'b1;
          end else begin
            wr0En  = 1'b1;
            sp_d   = sp_q + SPW'(1);
            commit = 1'b1;
          end
        end else if (bus.op_strobe) begin
          case (bus.op_code)
            OP_ADD, OP_SUB, OP_MUL, OP_SWAP: begin
              if (sp_q < SPW'(2)) begin
                undSet = 1'b1;
              end else begin
                a_d     = stack_q[tosIdx];
                b_d     = stack_q[nosIdx];
                opc_d   = opcode_e'(bus.op_code);
                state_d = S_EXEC;
              end
            end
            OP_DROP: begin
              if (isEmpty) begin
                undSet = 1'b1;
              end else begin
                sp_d   = sp_q - SPW'(1);
                commit = 1'b1;
              end
            end
            OP_DUP: begin
              if (isEmpty) begin
                undSet = 1'b1;
              end else if (isFull) begin
                ovfSet = 1'b1;
              end else begin
                wr0En   = 1'b1;
                wr0Data = stack_q[tosIdx];
                sp_d    = sp_q + SPW'(1);
                commit  = 1'b1;
              end
            end
            default: illSet = 1'b1;
          endcase
        end
      end

      S_EXEC: begin
        illSet = bus.push | bus.op_strobe;
        case (opc_q)
          OP_ADD:  r_d = b_q + a_q;
          OP_SUB:  r_d = b_q - a_q;
          OP_MUL:  r_d = b_q * a_q;
          default: r_d = r_q;
        endcase
        state_d = S_WRITE;
      end

      S_WRITE: begin
        illSet  = bus.push | bus.op_strobe;
        wr0En   = 1'b1;
        wr0Addr = nosIdx;
        if (opc_q == OP_SWAP) begin
          wr0Data = a_q;
          wr1En   = 1'b1;
        end else begin
          wr0Data = r_q;
          sp_d    = sp_q - SPW'(1);
        end
        commit  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // A commit that coincides with any raised error is not reported as done.
    done_d = commit & ~(ovfSet | undSet | illSet);
  end

  // Control and status registers; clear aborts any in-flight op without commit.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q  <= S_IDLE;
      sp_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      opc_q    <= OP_ADD;
      done_q   <= 1'b0;
      errOvf_q <= 1'b0;
      errUnd_q <= 1'b0;
      errIll_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sp_q     <= sp_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      opc_q    <= opc_d;
      done_q   <= done_d;
      errOvf_q <= errOvf_q | ovfSet;
      errUnd_q <= errUnd_q | undSet;
      errIll_q <= errIll_q | illSet;
    end
  end

  // Stack storage has no reset; sp alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (wr0En) stack_q[wr0Addr] <= wr0Data;
    if (wr1En) stack_q[wr1Addr] <= wr1Data;
  end

  assign bus.top           = isEmpty ? '0 : stack_q[tosIdx];
  assign bus.depth         = sp_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = done_q;
  assign bus.err_overflow  = errOvf_q;
  assign bus.err_underflow = errUnd_q;
  assign bus.err_illegal   = errIll_q;
endmodule

// File: tb/tb_rpn_stack_engine.sv
// Directed and random checks of rpn_stack_engine against a queue-based RPN model.
module tb_rpn_stack_engine;
  localparam int DEPTH = 8;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic clear;
  int   testCount = 0;
  int   failCount = 0;

  logic [DW-1:0] model[$];
  logic expOvf, expUnd, expIll;

  always #5 clk = ~clk;

  rpn_stack_engine_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  rpn_stack_engine #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  function automatic logic [DW-1:0] modelTop();
    return (model.size() == 0) ? '0 : model[model.size()-1];
  endfunction

  task automatic checkValue(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compares every visible output against the model's view of the stack.
  task automatic checkOutput(input string tag, input logic expDone, input logic expBusy);
    checkValue({tag, ".top"},   bus.top, modelTop());
    checkValue({tag, ".depth"}, DW'(bus.depth), DW'(model.size()));
    checkValue({tag, ".busy"},  DW'(bus.busy), DW'(expBusy));
    checkValue({tag, ".done"},  DW'(bus.done), DW'(expDone));
    checkValue({tag, ".ovf"},   DW'(bus.err_overflow), DW'(expOvf));
    checkValue({tag, ".und"},   DW'(bus.err_underflow), DW'(expUnd));
    checkValue({tag, ".ill"},   DW'(bus.err_illegal), DW'(expIll));
  endtask

  task automatic applyReset(input string tag);
    @(negedge clk);
    clear = 1'b1;
    model.delete();
    expOvf = 1'b0;
    expUnd = 1'b0;
    expIll = 1'b0;
    #1;
    checkOutput(tag, 1'b0, 1'b0);
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Drives one strobe cycle and predicts the outcome from plain RPN rules.
  task automatic applyStimulus(input string tag, input logic p, input logic s,
                               input logic [DW-1:0] val, input logic [2:0] code);
    logic multi, errNow, commit;
    logic [DW-1:0] a, b;
    multi = 1'b0;
    errNow = 1'b0;
    commit = 1'b0;
    if (p) begin
      if (s) begin expIll = 1'b1; errNow = 1'b1; end
      if (model.size() == DEPTH) begin
        expOvf = 1'b1; errNow = 1'b1;
      end else begin
        model.push_back(val); commit = 1'b1;
      end
    end else if (s) begin
      if (code <= 3'd3) begin
        if (model.size() < 2) begin expUnd = 1'b1; errNow = 1'b1; end
        else multi = 1'b1;
      end else if (code == 3'd4) begin
        if (model.size() == 0) begin expUnd = 1'b1; errNow = 1'b1; end
        else begin void'(model.pop_back()); commit = 1'b1; end
      end else if (code == 3'd5) begin
        if (model.size() == 0) begin expUnd = 1'b1; errNow = 1'b1; end
        else if (model.size() == DEPTH) begin expOvf = 1'b1; errNow = 1'b1; end
        else begin model.push_back(modelTop()); commit = 1'b1; end
      end else begin
        expIll = 1'b1; errNow = 1'b1;
      end
    end

    @(negedge clk);
    bus.push      = p;
    bus.op_strobe = s;
    bus.number    = val;
    bus.op_code   = code;
    @(negedge clk);
    bus.push      = 1'b0;
    bus.op_strobe = 1'b0;

    if (multi) begin
      checkValue({tag, ".exec.busy"}, DW'(bus.busy), DW'(1));
      checkValue({tag, ".exec.done"}, DW'(bus.done), DW'(0));
      @(negedge clk);
      checkValue({tag, ".write.busy"}, DW'(bus.busy), DW'(1));
      a = model.pop_back();
      b = model.pop_back();
      case (code)
        3'd0: model.push_back(b + a);
        3'd1: model.push_back(b - a);
        3'd2: model.push_back(b * a);
        default: begin model.push_back(a); model.push_back(b); end
      endcase
      @(negedge clk);
      commit = 1'b1;
    end
    checkOutput(tag, commit & ~errNow, 1'b0);
  endtask

  initial begin
    logic [2:0] code;
    int r;
    clear         = 1'b1;
    bus.push      = 1'b0;
    bus.op_strobe = 1'b0;
    bus.number    = '0;
    bus.op_code   = '0;
    expOvf = 1'b0;
    expUnd = 1'b0;
    expIll = 1'b0;
    #2;
    checkOutput("reset", 1'b0, 1'b0);
    @(negedge clk);
    clear = 1'b0;

    applyStimulus("push12", 1, 0, 32'd12, 3'd0);
    applyStimulus("push30", 1, 0, 32'd30, 3'd0);
    applyStimulus("add42",  0, 1, 32'd0, 3'd0);
    checkValue("add42.value", bus.top, 32'd42);

    applyReset("reset2");
    applyStimulus("push5", 1, 0, 32'd5, 3'd0);
    applyStimulus("push9", 1, 0, 32'd9, 3'd0);
    applyStimulus("sub",   0, 1, 32'd0, 3'd1);
    checkValue("sub.value", bus.top, 32'hFFFF_FFFC);
    applyStimulus("push3", 1, 0, 32'd3, 3'd0);
    applyStimulus("mul",   0, 1, 32'd0, 3'd2);
    checkValue("mul.value", bus.top, 32'hFFFF_FFF4);

    applyReset("reset3");
    for (int i = 1; i <= 8; i++) applyStimulus("fill", 1, 0, DW'(i), 3'd0);
    applyStimulus("push9full", 1, 0, 32'd9, 3'd0);
    checkValue("full.top", bus.top, 32'd8);
    applyStimulus("dupFull",  0, 1, 32'd0, 3'd5);
    applyStimulus("dropFull", 0, 1, 32'd0, 3'd4);
    checkValue("drop.top", bus.top, 32'd7);

    applyReset("reset4");
    applyStimulus("addEmpty",  0, 1, 32'd0, 3'd0);
    applyStimulus("dropEmpty", 0, 1, 32'd0, 3'd4);
    applyStimulus("push4",     1, 0, 32'd4, 3'd0);
    applyStimulus("dup4",      0, 1, 32'd0, 3'd5);

    applyReset("reset5");
    applyStimulus("push7", 1, 0, 32'd7, 3'd0);
    applyStimulus("push2", 1, 0, 32'd2, 3'd0);
    // SWAP with a push intruding while the engine is busy.
    @(negedge clk);
    bus.op_strobe = 1'b1;
    bus.op_code   = 3'd3;
    @(negedge clk);
    bus.op_strobe = 1'b0;
    bus.push      = 1'b1;
    bus.number    = 32'd99;
    checkValue("swapBusy.exec", DW'(bus.busy), DW'(1));
    @(negedge clk);
    bus.push = 1'b0;
    checkValue("swapBusy.write", DW'(bus.busy), DW'(1));
    @(negedge clk);
    void'(model.pop_back());
    void'(model.pop_back());
    model.push_back(32'd2);
    model.push_back(32'd7);
    expIll = 1'b1;
    checkOutput("swapBusy", 1'b1, 1'b0);
    applyStimulus("dropSwap", 0, 1, 32'd0, 3'd4);
    checkValue("dropSwap.top", bus.top, 32'd2);
    applyStimulus("pushAndOp", 1, 1, 32'd55, 3'd4);
    applyStimulus("illegal6",  0, 1, 32'd0, 3'd6);

    applyReset("reset6");
    applyStimulus("push100", 1, 0, 32'd100, 3'd0);
    applyStimulus("push200", 1, 0, 32'd200, 3'd0);
    @(negedge clk);
    bus.op_strobe = 1'b1;
    bus.op_code   = 3'd0;
    @(negedge clk);
    bus.op_strobe = 1'b0;
    #1;
    clear = 1'b1;
    model.delete();
    #1;
    checkOutput("clearExec", 1'b0, 1'b0);
    @(negedge clk);
    clear = 1'b0;
    applyStimulus("push6", 1, 0, 32'd6, 3'd0);

    applyReset("resetRand");
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      code = 3'($urandom_range(0, 7));
      if (r == 9)      applyStimulus("randBoth", 1, 1, $urandom, code);
      else if (r < 4)  applyStimulus("randPush", 1, 0, $urandom, code);
      else             applyStimulus("randOp",   0, 1, 32'd0, code);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
